// File: rtl/regfile_dump_reader.sv
// Sequential read-out engine for the register file: walks a wrap-around index range,
// captures each word from the combinational read port and streams it with valid/ready.
module regfile_dump_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_reg,
    input  logic [ADDR_WIDTH-1:0] end_reg,
    output logic [ADDR_WIDTH-1:0] readReg,
    input  logic [DATA_WIDTH-1:0] readData,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] TOP_INDEX = '1;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [ADDR_WIDTH-1:0]   last;
    logic [ADDR_WIDTH-1:0]   idx_inc;
    logic                    handshake;
    logic                    final_word;
    logic                    load_range;
    logic                    capture;
    logic [ADDR_WIDTH-1:0]   capture_index;
    logic [DATA_WIDTH-1:0]   capture_data;

    assign idx_inc    = idx + 1'b1;
    assign handshake  = (state == SEND) && out_valid && out_ready;
    assign final_word = (out_index == last);
    assign busy       = (state != IDLE);

    // SEND always presents the next index, so the address never depends on out_ready.
    always_comb begin
        state_next    = state;
        load_range    = 1'b0;
        capture       = 1'b0;
        capture_index = idx;
        readReg       = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load_range = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                readReg    = idx;
                capture    = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                readReg = idx_inc;
                if (handshake) begin
                    if (final_word) begin
                        state_next = IDLE;
                    end else begin
                        capture       = 1'b1;
                        capture_index = idx_inc;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign capture_data = (ZERO_REG && (capture_index == TOP_INDEX)) ? '0 : readData;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            last      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load_range) begin
                idx  <= start_reg;
                last <= end_reg;
            end
            if (capture) begin
                out_data  <= capture_data;
                out_index <= capture_index;
                out_valid <= 1'b1;
                if (state == SEND) begin
                    idx <= idx_inc;
                end
            end
            if (handshake && final_word) begin
                out_valid <= 1'b0;
                done      <= 1'b1;
            end
        end
    end

endmodule
